// File: rtl/logistic_sched.sv
// logistic_sched: debounces the sample keys, aligns recomputes to vertical blanking and sequences clear/compute.
// Optional feature: define AUTO_CYCLE_EN to auto-advance the sample every AUTO_FRAMES blanking intervals.
module logistic_sched #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [3:0]  CLEAR_CYCLES    = 4'd4,
    parameter logic [23:0] CALC_TIMEOUT    = 24'd4000000,
    parameter logic [7:0]  AUTO_FRAMES     = 8'd120
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       vnotactive,
    input  logic [4:0] key_d,
    input  logic [4:0] key_c,
    input  logic       calc_done,
    output logic [3:0] sample_num,
    output logic       logistic_rst_n,
    output logic       calc_en,
    output logic       busy,
    output logic       frame_valid,
    output logic       timeout_err
);

    localparam logic [3:0] NONE_CODE = 4'hF;

    typedef enum logic [1:0] {IDLE, WAIT_BLANK, CLEAR, CALC} state_t;

    state_t      state;
    logic [9:0]  keys_n;
    logic [3:0]  key_code;
    logic [3:0]  last_code;
    logic [15:0] stable_cnt;
    logic [15:0] cnt_next;
    logic        code_changed;
    logic        just_stable;
    logic        armed;
    logic        key_accept;
    logic [3:0]  key_accept_code;
    logic        pending_valid;
    logic [3:0]  pending_code;
    logic [3:0]  req_code;
    logic        vna_prev;
    logic        blank_rise;
    logic [3:0]  clr_cnt;
    logic [23:0] calc_cnt;
    logic        auto_post;
    logic [3:0]  auto_code;

    assign keys_n     = {key_c, key_d};
    assign blank_rise = vnotactive && !vna_prev;

    // Descending scan so the lowest-numbered pressed key wins.
    always_comb begin
        key_code = NONE_CODE;
        for (int i = 9; i >= 0; i--) begin
            if (!keys_n[i]) key_code = 4'(i);
        end
    end

    always_comb begin
        code_changed = (key_code != last_code);
        if (code_changed)
            cnt_next = 16'd1;
        else if (stable_cnt == DEBOUNCE_CYCLES)
            cnt_next = stable_cnt;
        else
            cnt_next = stable_cnt + 16'd1;
        just_stable = (cnt_next == DEBOUNCE_CYCLES) &&
                      (code_changed || (stable_cnt != DEBOUNCE_CYCLES));
    end

    // A press is only accepted once a stable release has re-armed the debouncer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_code       <= NONE_CODE;
            stable_cnt      <= 16'd0;
            armed           <= 1'b1;
            key_accept      <= 1'b0;
            key_accept_code <= 4'd0;
            vna_prev        <= 1'b1;
        end else begin
            last_code  <= key_code;
            stable_cnt <= cnt_next;
            key_accept <= 1'b0;
            vna_prev   <= vnotactive;
            if (just_stable) begin
                if (key_code == NONE_CODE) begin
                    armed <= 1'b1;
                end else if (armed) begin
                    key_accept      <= 1'b1;
                    key_accept_code <= key_code;
                    armed           <= 1'b0;
                end
            end
        end
    end

`ifdef AUTO_CYCLE_EN
    logic [7:0] frame_cnt;
    logic       auto_tick;

    assign auto_tick = blank_rise && (state == IDLE) && !pending_valid;
    assign auto_post = auto_tick && !key_accept && (frame_cnt == AUTO_FRAMES - 8'd1);
    assign auto_code = (sample_num == 4'd9) ? 4'd0 : sample_num + 4'd1;

    always_ff @(posedge CLK) begin
        if (RST)
            frame_cnt <= 8'd0;
        else if (key_accept || auto_post)
            frame_cnt <= 8'd0;
        else if (auto_tick)
            frame_cnt <= frame_cnt + 8'd1;
    end
`else
    logic unused_auto_frames;

    assign auto_post          = 1'b0;
    assign auto_code          = 4'd0;
    assign unused_auto_frames = ^AUTO_FRAMES;
`endif

    // Single-entry mailbox: a new request overwrites an unconsumed one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_valid <= 1'b0;
            pending_code  <= 4'd0;
        end else if (key_accept) begin
            pending_valid <= 1'b1;
            pending_code  <= key_accept_code;
        end else if (auto_post) begin
            pending_valid <= 1'b1;
            pending_code  <= auto_code;
        end else if ((state == IDLE) && pending_valid) begin
            pending_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= WAIT_BLANK;
            req_code       <= 4'd0;
            sample_num     <= 4'd0;
            logistic_rst_n <= 1'b0;
            calc_en        <= 1'b0;
            busy           <= 1'b1;
            frame_valid    <= 1'b0;
            timeout_err    <= 1'b0;
            clr_cnt        <= 4'd0;
            calc_cnt       <= 24'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending_valid) begin
                        state    <= WAIT_BLANK;
                        req_code <= pending_code;
                        busy     <= 1'b1;
                    end
                end
                WAIT_BLANK: begin
                    if (blank_rise) begin
                        state          <= CLEAR;
                        sample_num     <= req_code;
                        frame_valid    <= 1'b0;
                        logistic_rst_n <= 1'b0;
                        clr_cnt        <= 4'd0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLEAR_CYCLES - 4'd1) begin
                        state          <= CALC;
                        logistic_rst_n <= 1'b1;
                        calc_en        <= 1'b1;
                        calc_cnt       <= 24'd0;
                    end else begin
                        clr_cnt <= clr_cnt + 4'd1;
                    end
                end
                CALC: begin
                    // calc_done takes precedence over a timeout landing on the same cycle.
                    if (calc_done) begin
                        state       <= IDLE;
                        calc_en     <= 1'b0;
                        frame_valid <= 1'b1;
                        busy        <= 1'b0;
                    end else if (calc_cnt == CALC_TIMEOUT - 24'd1) begin
                        state       <= IDLE;
                        calc_en     <= 1'b0;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        calc_cnt <= calc_cnt + 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logistic_sched.sv
// tb_logistic_sched: directed and randomized key/blanking scenarios checked against a behavioural model.
module tb_logistic_sched;

    localparam logic [15:0] DEB   = 16'd20;
    localparam logic [3:0]  CLR   = 4'd4;
    localparam logic [23:0] TMO   = 24'd1000;
    localparam logic [7:0]  AUTOF = 8'd2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       vnotactive;
    logic       calc_done;
    logic [9:0] keys_n;
    logic [4:0] key_d;
    logic [4:0] key_c;
    logic [3:0] sample_num;
    logic       logistic_rst_n;
    logic       calc_en;
    logic       busy;
    logic       frame_valid;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    int lastSample = 0;

    assign key_d = keys_n[4:0];
    assign key_c = keys_n[9:5];

    always #5 CLK = ~CLK;

    logistic_sched #(
        .DEBOUNCE_CYCLES(DEB),
        .CLEAR_CYCLES(CLR),
        .CALC_TIMEOUT(TMO),
        .AUTO_FRAMES(AUTOF)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .vnotactive(vnotactive),
        .key_d(key_d),
        .key_c(key_c),
        .calc_done(calc_done),
        .sample_num(sample_num),
        .logistic_rst_n(logistic_rst_n),
        .calc_en(calc_en),
        .busy(busy),
        .frame_valid(frame_valid),
        .timeout_err(timeout_err)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Key index 0..9 is the position of the first low key in {key_c, key_d}.
    function automatic int expectedSample(input logic [9:0] k);
        for (int i = 0; i < 10; i++) begin
            if (!k[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [9:0] keyMask(input int idx);
        logic [9:0] m;
        m = '1;
        m[idx] = 1'b0;
        return m;
    endfunction

    task automatic applyStimulus(input logic [9:0] pressed, input int bounces);
        for (int b = 0; b < bounces; b++) begin
            keys_n = pressed;
            tick($urandom_range(1, int'(DEB) / 2));
            keys_n = '1;
            tick($urandom_range(1, int'(DEB) / 2));
        end
        keys_n = pressed;
    endtask

    task automatic releaseKeys(input logic [9:0] pressed, input int bounces);
        for (int b = 0; b < bounces; b++) begin
            keys_n = '1;
            tick($urandom_range(1, int'(DEB) / 2));
            keys_n = pressed;
            tick($urandom_range(1, int'(DEB) / 2));
        end
        keys_n = '1;
        tick(int'(DEB) + 5);
    endtask

    // From the first stable sample, the request lands after DEB cycles and busy follows two edges later.
    task automatic pressIdle(input string tag, input logic [9:0] pressed, input int bounces);
        applyStimulus(pressed, bounces);
        tick(int'(DEB) + 1);
        checkOutput({tag, " busy before accept"}, 32'(busy), 32'd0);
        tick(1);
        checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
    endtask

    task automatic enterCalc(input string tag, input int expSample);
        int n;
        tick(3);
        vnotactive = 1'b1;
        tick(1);
        checkOutput({tag, " sample_num"}, 32'(sample_num), 32'(expSample));
        checkOutput({tag, " rst_n in clear"}, 32'(logistic_rst_n), 32'd0);
        checkOutput({tag, " frame_valid cleared"}, 32'(frame_valid), 32'd0);
        vnotactive = 1'b0;
        n = 0;
        while (logistic_rst_n !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        checkOutput({tag, " clear length"}, 32'(n), 32'(CLR));
        checkOutput({tag, " calc_en with rst_n"}, 32'(calc_en), 32'd1);
        lastSample = expSample;
    endtask

    task automatic finishCalc(input string tag, input int delay);
        tick(delay);
        checkOutput({tag, " calc_en held"}, 32'(calc_en), 32'd1);
        calc_done = 1'b1;
        tick(1);
        calc_done = 1'b0;
        checkOutput({tag, " calc_en off"}, 32'(calc_en), 32'd0);
        checkOutput({tag, " frame_valid"}, 32'(frame_valid), 32'd1);
        checkOutput({tag, " busy off"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [9:0] m;
        logic [9:0] m2;
        int exp;
        int n;

        keys_n = '1;
        vnotactive = 1'b0;
        calc_done = 1'b0;
        RST = 1'b1;
        tick(3);
        checkOutput("reset sample_num", 32'(sample_num), 32'd0);
        checkOutput("reset rst_n", 32'(logistic_rst_n), 32'd0);
        checkOutput("reset calc_en", 32'(calc_en), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd1);
        checkOutput("reset frame_valid", 32'(frame_valid), 32'd0);
        checkOutput("reset timeout_err", 32'(timeout_err), 32'd0);
        RST = 1'b0;

        $display("[TB] startup recompute");
        tick(95);
        enterCalc("startup", 0);
        finishCalc("startup", 390);

        $display("[TB] bouncy key_c[2] held long");
        m = keyMask(7);
        pressIdle("key_c2", m, 3);
        enterCalc("key_c2", expectedSample(m));
        finishCalc("key_c2", $urandom_range(0, 50));
        tick(3 * int'(DEB));
        checkOutput("key_c2 single request", 32'(busy), 32'd0);
        releaseKeys(m, 2);

        $display("[TB] key_d[1] and key_c[0] together");
        m = keyMask(1) & keyMask(5);
        pressIdle("dual", m, 1);
        releaseKeys(m, 1);
        enterCalc("dual", expectedSample(m));
        finishCalc("dual", $urandom_range(0, 50));

        $display("[TB] random key patterns");
        for (int it = 0; it < 4; it++) begin
            m = 10'($urandom);
            if (&m) m[$urandom_range(0, 9)] = 1'b0;
            exp = expectedSample(m);
            pressIdle("random", m, $urandom_range(0, 3));
            releaseKeys(m, $urandom_range(0, 2));
            enterCalc("random", exp);
            finishCalc("random", $urandom_range(0, 60));
        end

        $display("[TB] presses during calc, latest wins");
        m = keyMask(2);
        pressIdle("midcalc start", m, 0);
        releaseKeys(m, 0);
        enterCalc("midcalc start", 2);
        m = keyMask(3);
        applyStimulus(m, 1);
        tick(int'(DEB) + 3);
        releaseKeys(m, 1);
        m2 = keyMask(9);
        applyStimulus(m2, 0);
        tick(int'(DEB) + 3);
        releaseKeys(m2, 1);
        checkOutput("midcalc not aborted", 32'(calc_en), 32'd1);
        checkOutput("midcalc sample kept", 32'(sample_num), 32'd2);
        finishCalc("midcalc start", 5);
        tick(1);
        checkOutput("midcalc pending serviced", 32'(busy), 32'd1);
        enterCalc("midcalc latest", 9);
        finishCalc("midcalc latest", 10);
        tick(2 * int'(DEB));
        checkOutput("midcalc sample 3 dropped", 32'(busy), 32'd0);

        $display("[TB] calc timeout");
        m = keyMask(4);
        pressIdle("timeout", m, 0);
        releaseKeys(m, 0);
        enterCalc("timeout", 4);
        n = 0;
        while (calc_en === 1'b1 && n < 2000) begin
            tick(1);
            n++;
        end
        checkOutput("timeout calc length", 32'(n), 32'(TMO));
        checkOutput("timeout_err set", 32'(timeout_err), 32'd1);
        checkOutput("timeout frame_valid", 32'(frame_valid), 32'd0);
        checkOutput("timeout busy", 32'(busy), 32'd0);
        calc_done = 1'b1;
        tick(1);
        calc_done = 1'b0;
        tick(2);
        checkOutput("stray calc_done ignored", 32'(frame_valid), 32'd0);
        checkOutput("stray calc_done busy", 32'(busy), 32'd0);

        $display("[TB] reset mid-operation");
        m = keyMask(6);
        pressIdle("midreset", m, 0);
        releaseKeys(m, 0);
        enterCalc("midreset", 6);
        m = keyMask(8);
        applyStimulus(m, 0);
        tick(int'(DEB) + 3);
        keys_n = '1;
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        checkOutput("midreset sample_num", 32'(sample_num), 32'd0);
        checkOutput("midreset rst_n", 32'(logistic_rst_n), 32'd0);
        checkOutput("midreset calc_en", 32'(calc_en), 32'd0);
        checkOutput("midreset busy", 32'(busy), 32'd1);
        checkOutput("midreset timeout_err", 32'(timeout_err), 32'd0);
        tick(10);
        enterCalc("rearm", 0);
        finishCalc("rearm", 20);
        tick(2 * int'(DEB));
        checkOutput("midreset pending lost", 32'(busy), 32'd0);

`ifdef AUTO_CYCLE_EN
        $display("[TB] auto advance");
        for (int f = 0; f < int'(AUTOF); f++) begin
            vnotactive = 1'b1;
            tick(1);
            vnotactive = 1'b0;
            tick(3);
        end
        checkOutput("auto request posted", 32'(busy), 32'd1);
        enterCalc("auto", (lastSample + 1) % 10);
        finishCalc("auto", 10);
`else
        $display("[TB] no auto advance");
        for (int f = 0; f < 4; f++) begin
            vnotactive = 1'b1;
            tick(1);
            vnotactive = 1'b0;
            tick(3);
            checkOutput("no auto request", 32'(busy), 32'd0);
        end
        checkOutput("no auto sample kept", 32'(sample_num), 32'(lastSample));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
